// File: rtl/dmem_arbiter_if.sv
// Purpose : bundles both requester ports and the data-memory port of dmem_arbiter.
// Latency : n/a (wires only).
// Backpres: n/a; the requester holds req/we/addr/wdata until its gnt pulse.
// Ports   : req/we/addr/wdata in, gnt/rvalid/wack/rdata out per requester;
//           mem_addr/mem_write_data/mem_write/mem_read out, mem_read_data in.
interface dmem_arbiter_if #(
  parameter int DW = 19,
  parameter int AW = 4
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;

  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic          wack0;
  logic          wack1;
  logic [DW-1:0] rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_write;
  logic          mem_read;
  logic [DW-1:0] mem_read_data;

  // Arbiter side.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
    output gnt0, gnt1, rvalid0, rvalid1, wack0, wack1, rdata,
           mem_addr, mem_write_data, mem_write, mem_read
  );

  // Requester plus memory side.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
    input  gnt0, gnt1, rvalid0, rvalid1, wack0, wack1, rdata,
           mem_addr, mem_write_data, mem_write, mem_read
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose : round-robin arbiter giving two requesters access to one data memory.
// Latency : gnt at N, memory access at N+1, rvalid/wack at N+2, next gnt at N+3 earliest.
// Backpres: one transaction in flight; requests are held off by withholding gnt.
// Ports   : clk, reset (sync, active low), bus (dmem_arbiter_if.slave).
// DW/AW must match the parameters of the connected interface instance.
module dmem_arbiter #(
  parameter int DW = 19,
  parameter int AW = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic          last;        // last winner; 1 after reset so requester 0 wins the first tie
  logic          cur_id;      // requester owning the transaction in flight
  logic          cur_we;
  logic [AW-1:0] mem_addr_q;  // doubles as the captured address
  logic [DW-1:0] mem_wdata_q; // doubles as the captured write data
  logic [DW-1:0] rdata_q;

  logic          grant;
  logic          win1;
  logic          win_we;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic          wack0;
  logic          wack1;
  logic          mem_read;
  logic          mem_write;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    wack0     = 1'b0;
    wack1     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    // On a tie the requester that did not win last time goes next.
    win1      = (bus.req0 && bus.req1) ? ~last : bus.req1;
    win_we    = win1 ? bus.we1 : bus.we0;
    case (state)
      IDLE: begin
        // Gate with reset so no grant appears while reset is asserted.
        if (reset && (bus.req0 || bus.req1)) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_read  = ~cur_we;
        mem_write = cur_we;
        state_nxt = RESP;
      end
      RESP: begin
        rvalid0   = ~cur_we & ~cur_id;
        rvalid1   = ~cur_we &  cur_id;
        wack0     =  cur_we & ~cur_id;
        wack1     =  cur_we &  cur_id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    gnt0 = grant & ~win1;
    gnt1 = grant &  win1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last        <= 1'b1;
      cur_id      <= 1'b0;
      cur_we      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      if (grant) begin
        last       <= win1;
        cur_id     <= win1;
        cur_we     <= win_we;
        mem_addr_q <= win1 ? bus.addr1 : bus.addr0;
        // Only writes update the data bus so it keeps the last written value.
        if (win_we) mem_wdata_q <= win1 ? bus.wdata1 : bus.wdata0;
      end
      if (state == ACCESS && !cur_we) rdata_q <= bus.mem_read_data;
    end
  end

  assign bus.gnt0           = gnt0;
  assign bus.gnt1           = gnt1;
  assign bus.rvalid0        = rvalid0;
  assign bus.rvalid1        = rvalid1;
  assign bus.wack0          = wack0;
  assign bus.wack1          = wack1;
  assign bus.rdata          = rdata_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write_data = mem_wdata_q;
  assign bus.mem_read       = mem_read;
  assign bus.mem_write      = mem_write;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [18:0] mem [16];

  dmem_arbiter_if #(.DW(19), .AW(4)) bus ();

  dmem_arbiter #(.DW(19), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational-read, clocked-write data memory.
  assign bus.mem_read_data = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_write_data;
  end

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.req0 = 1'b1;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.wack0, bus.wack1,
         bus.mem_read, bus.mem_write} !== 8'h00) begin
      errors++;
      $display("FAIL reset_pulses: got %b required 00000000",
               {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.wack0, bus.wack1,
                bus.mem_read, bus.mem_write});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_write_data, bus.rdata} !== 42'h0) begin
      errors++;
      $display("FAIL reset_regs: addr %h wdata %h rdata %h required all 0",
               bus.mem_addr, bus.mem_write_data, bus.rdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
      errors++;
      $display("FAIL reset_no_grant: got %b required 00", {bus.gnt0, bus.gnt1});
    end
    bus.req0 = 1'b0;
    reset    = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd1;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL read_gnt: got %b required 10", {bus.gnt0, bus.gnt1});
    end
    @(negedge clk);
    bus.req0 = 1'b0;
    #1;
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.mem_addr} !== {2'b10, 4'd1}) begin
      errors++;
      $display("FAIL read_access: rd/wr/addr %b/%b/%h required 1/0/1",
               bus.mem_read, bus.mem_write, bus.mem_addr);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.rvalid0, bus.rvalid1, bus.wack0, bus.wack1} !== 4'b1000 ||
        bus.rdata !== 19'd7) begin
      errors++;
      $display("FAIL read_resp: pulses %b rdata %h required 1000 / 7",
               {bus.rvalid0, bus.rvalid1, bus.wack0, bus.wack1}, bus.rdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.rvalid0, bus.mem_read} !== 2'b00) begin
      errors++;
      $display("FAIL read_done: rvalid0/mem_read %b required 00", {bus.rvalid0, bus.mem_read});
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 4'd3; bus.wdata1 = 19'h1234;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL write_gnt: got %b required 01", {bus.gnt0, bus.gnt1});
    end
    @(negedge clk);
    bus.req1 = 1'b0; bus.wdata1 = 19'h0;
    #1;
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.mem_addr} !== {2'b01, 4'd3} ||
        bus.mem_write_data !== 19'h1234) begin
      errors++;
      $display("FAIL write_access: rd/wr/addr/data %b/%b/%h/%h required 0/1/3/1234",
               bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_write_data);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.rvalid0, bus.rvalid1, bus.wack0, bus.wack1} !== 4'b0001 ||
        bus.rdata !== 19'd7) begin
      errors++;
      $display("FAIL write_resp: pulses %b rdata %h required 0001 / 7",
               {bus.rvalid0, bus.rvalid1, bus.wack0, bus.wack1}, bus.rdata);
    end
    // Read back through requester 1.
    @(negedge clk);
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd3;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL readback_gnt: got %b required 01", {bus.gnt0, bus.gnt1});
    end
    @(negedge clk);
    bus.req1 = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.rvalid1 !== 1'b1 || bus.rdata !== 19'h1234) begin
      errors++;
      $display("FAIL readback_data: rvalid1 %b rdata %h required 1 / 1234",
               bus.rvalid1, bus.rdata);
    end
  endtask

  task automatic test_tie();
    logic       e_g0, e_g1, e_r0, e_r1;
    logic [18:0] e_rd;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd2;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd5;
    for (int c = 0; c < 12; c++) begin
      #1;
      e_g0 = (c % 3 == 0) && ((c / 3) % 2 == 0);
      e_g1 = (c % 3 == 0) && ((c / 3) % 2 == 1);
      e_r0 = (c % 3 == 2) && ((c / 3) % 2 == 0);
      e_r1 = (c % 3 == 2) && ((c / 3) % 2 == 1);
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1} !== {e_g0, e_g1, e_r0, e_r1}) begin
        errors++;
        $display("FAIL tie_cycle%0d: gnt0/gnt1/rv0/rv1 %b required %b", c,
                 {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1}, {e_g0, e_g1, e_r0, e_r1});
      end
      if (c % 3 == 2) begin
        e_rd = ((c / 3) % 2 == 0) ? 19'h102 : 19'h105;
        checks++;
        if (bus.rdata !== e_rd) begin
          errors++;
          $display("FAIL tie_rdata%0d: got %h required %h", c, bus.rdata, e_rd);
        end
      end
      @(negedge clk);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic test_stability();
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd4;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL stab_gnt: got %b required 10", {bus.gnt0, bus.gnt1});
    end
    @(negedge clk);
    bus.req0 = 1'b0; bus.addr0 = 4'd9;
    #1;
    checks++;
    if (bus.mem_addr !== 4'd4 || bus.mem_read !== 1'b1) begin
      errors++;
      $display("FAIL stab_addr: mem_addr %h mem_read %b required 4 / 1",
               bus.mem_addr, bus.mem_read);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata !== 19'd3) begin
      errors++;
      $display("FAIL stab_rdata: rvalid0 %b rdata %h required 1 / 3", bus.rvalid0, bus.rdata);
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd1;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_gnt: got %b required 10", {bus.gnt0, bus.gnt1});
    end
    @(negedge clk);
    bus.req0 = 1'b0;
    reset    = 1'b0;
    #1;
    checks++;
    if (bus.mem_read !== 1'b1) begin
      errors++;
      $display("FAIL midrst_access: mem_read %b required 1", bus.mem_read);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.wack0, bus.wack1,
         bus.mem_read, bus.mem_write} !== 8'h00 ||
        {bus.mem_addr, bus.mem_write_data, bus.rdata} !== 42'h0) begin
      errors++;
      $display("FAIL midrst_outputs: pulses %b addr %h wdata %h rdata %h required all 0",
               {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.wack0, bus.wack1,
                bus.mem_read, bus.mem_write}, bus.mem_addr, bus.mem_write_data, bus.rdata);
    end
    reset = 1'b1;
    bus.req0 = 1'b1; bus.addr0 = 4'd1;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd5;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_tie: got %b required 10", {bus.gnt0, bus.gnt1});
    end
    @(negedge clk);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata !== 19'd7) begin
      errors++;
      $display("FAIL midrst_resp: rvalid0 %b rdata %h required 1 / 7", bus.rvalid0, bus.rdata);
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.wack0, bus.wack1,
           bus.mem_read, bus.mem_write} !== 8'h00 || bus.rdata !== 19'd7) begin
        errors++;
        $display("FAIL idle_cycle%0d: pulses %b rdata %h required 00000000 / 7", c,
                 {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.wack0, bus.wack1,
                  bus.mem_read, bus.mem_write}, bus.rdata);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16; i++) mem[i] = 19'h100 + 19'(i);
    mem[1] = 19'd7;
    mem[4] = 19'd3;
    reset      = 1'b0;
    bus.req0   = 1'b0; bus.req1   = 1'b0;
    bus.we0    = 1'b0; bus.we1    = 1'b0;
    bus.addr0  = 4'd0; bus.addr1  = 4'd0;
    bus.wdata0 = 19'd0; bus.wdata1 = 19'd0;

    test_reset();
    test_single_read();
    test_write();
    test_tie();
    test_stability();
    test_reset_mid_read();
    test_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
